// File: rtl/audio_pwm_mc_pkg.sv
// Shared constants and types for the audio_pwm_mc peripheral.
package audio_pkg;

  // Default configuration
  localparam int unsigned DEF_NUM_CH     = 2;
  localparam int unsigned DEF_SAMPLE_W   = 8;
  localparam int unsigned DEF_FIFO_DEPTH = 16;
  localparam int unsigned DEF_LOW_WM     = 4;
  localparam int unsigned DEF_DIV_W      = 16;

  // Register word offsets
  localparam logic [1:0] CTRL_OFS   = 2'd0;
  localparam logic [1:0] DIV_OFS    = 2'd1;
  localparam logic [1:0] STATUS_OFS = 2'd2;
  localparam logic [1:0] DATA_OFS   = 2'd3;

  // CTRL bit positions
  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;
  localparam int unsigned CTRL_FLUSH_BIT  = 2;

  // STATUS bit positions
  localparam int unsigned ST_LEVEL_LSB    = 0;
  localparam int unsigned ST_EMPTY_BIT    = 8;
  localparam int unsigned ST_FULL_BIT     = 9;
  localparam int unsigned ST_UNDERRUN_BIT = 10;
  localparam int unsigned ST_OVERFLOW_BIT = 11;
  localparam int unsigned ST_IDX_LSB      = 12;

  // One sample per channel, channel 0 in the low bits
  typedef logic [DEF_NUM_CH-1:0][DEF_SAMPLE_W-1:0] frame_t;

endpackage

// File: rtl/audio_pwm_mc_sync_fifo.sv
// Synchronous frame FIFO with flush; flush overrides push and pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned LW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata_c,
  output logic             full_c,
  output logic             empty_c,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Qualify requests: a push on full is accepted only alongside a pop
  always_comb begin
    full_c  = (level == LW'(DEPTH));
    empty_c = (level == '0);
    do_pop  = pop && !empty_c && !flush;
    do_push = push && (!full_c || do_pop) && !flush;
    rdata_c = mem[rd_ptr];
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/audio_pwm_mc.sv
// Multi-channel audio PWM peripheral: register file, frame staging,
// sample-rate divider, frame FIFO, per-channel PWM and watermark irq.
// Build option: AUDIO_PWM_SIGMA_DELTA_EN swaps the PWM compare for a
// first-order sigma-delta modulator on each channel.
module audio_pwm_mc
  import audio_pkg::*;
#(
  parameter int unsigned NUM_CH     = DEF_NUM_CH,
  parameter int unsigned SAMPLE_W   = DEF_SAMPLE_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned LOW_WM     = DEF_LOW_WM,
  parameter int unsigned DIV_W      = DEF_DIV_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [1:0]        addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic [NUM_CH-1:0] pwm_o,
  output logic              irq_o
);

  localparam int unsigned FRAME_W = NUM_CH * SAMPLE_W;
  localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH) + 1;

  typedef logic [NUM_CH-1:0][SAMPLE_W-1:0] ch_frame_t;

  logic             enable;
  logic             irq_en;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_cnt;
  logic             underrun;
  logic             overflow;
  logic [2:0]       idx;
  ch_frame_t        staging;
  ch_frame_t        pending;
  ch_frame_t        duty;
  ch_frame_t        push_frame;
  ch_frame_t        head_frame;
  logic [SAMPLE_W-1:0] pwm_cnt;

  logic wr_ctrl, wr_div, wr_status, wr_data;
  logic flush, frame_done, tick, pop_req, pop_eff, wrap;
  logic underrun_set, overflow_set;
  logic fifo_full, fifo_empty;
  logic [LVL_W-1:0]   level;
  logic [FRAME_W-1:0] fifo_rdata;
  logic [31:0]        status_word;
  logic               unused_wdata;

  assign unused_wdata = ^wdata_i;

  // Write decode, frame assembly and playback event detection
  always_comb begin
    wr_ctrl    = we_i && (addr_i == CTRL_OFS);
    wr_div     = we_i && (addr_i == DIV_OFS);
    wr_status  = we_i && (addr_i == STATUS_OFS);
    wr_data    = we_i && (addr_i == DATA_OFS);
    flush      = wr_ctrl && wdata_i[CTRL_FLUSH_BIT];
    frame_done = wr_data && (idx == 3'(NUM_CH - 1));
    push_frame = staging;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (idx == 3'(c)) push_frame[c] = wdata_i[SAMPLE_W-1:0];
    end
    head_frame   = fifo_rdata;
    tick         = enable && (div_cnt == div_q);
    pop_req      = tick && !flush;
    pop_eff      = pop_req && !fifo_empty;
    underrun_set = pop_req && fifo_empty;
    overflow_set = frame_done && fifo_full && !pop_eff;
    wrap         = enable && (pwm_cnt == '1);
  end

  sync_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (frame_done),
    .pop     (pop_req),
    .flush   (flush),
    .wdata   (push_frame),
    .rdata_c (fifo_rdata),
    .full_c  (fifo_full),
    .empty_c (fifo_empty),
    .level   (level)
  );

  // Control registers, staging, sticky flags, divider and PWM timebase
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enable   <= 1'b0;
      irq_en   <= 1'b0;
      div_q    <= '0;
      div_cnt  <= '0;
      underrun <= 1'b0;
      overflow <= 1'b0;
      idx      <= '0;
      staging  <= '0;
      pending  <= '0;
      duty     <= '0;
      pwm_cnt  <= '0;
      irq_o    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        enable <= wdata_i[CTRL_EN_BIT];
        irq_en <= wdata_i[CTRL_IRQ_EN_BIT];
      end
      if (wr_div) div_q <= wdata_i[DIV_W-1:0];
      if (flush) begin
        idx <= '0;
      end else if (wr_data) begin
        staging <= push_frame;
        idx     <= frame_done ? 3'd0 : idx + 3'd1;
      end
      underrun <= underrun_set ||
                  (underrun && !(wr_status && wdata_i[ST_UNDERRUN_BIT]));
      overflow <= overflow_set ||
                  (overflow && !(wr_status && wdata_i[ST_OVERFLOW_BIT]));
      if (!enable)  div_cnt <= '0;
      else if (tick) div_cnt <= '0;
      else           div_cnt <= div_cnt + DIV_W'(1);
      if (pop_eff) pending <= head_frame;
      pwm_cnt <= enable ? pwm_cnt + SAMPLE_W'(1) : '0;
      if (wrap) duty <= pending;
      irq_o <= irq_en && (level <= LVL_W'(LOW_WM));
    end
  end

`ifdef AUDIO_PWM_SIGMA_DELTA_EN
  logic [NUM_CH-1:0][SAMPLE_W:0] acc;

  // First-order sigma-delta per channel; the carry drives the output
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc   <= '0;
      pwm_o <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (enable) begin
          acc[c]   <= {1'b0, acc[c][SAMPLE_W-1:0]} + {1'b0, duty[c]};
          pwm_o[c] <= acc[c][SAMPLE_W];
        end else begin
          pwm_o[c] <= 1'b0;
        end
      end
    end
  end
`else
  // PWM compare per channel against the shared counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_o <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        pwm_o[c] <= enable && (pwm_cnt < duty[c]);
      end
    end
  end
`endif

  // Combinational register read mux
  always_comb begin
    status_word = '0;
    status_word[ST_LEVEL_LSB +: 8]    = 8'(level);
    status_word[ST_EMPTY_BIT]         = fifo_empty;
    status_word[ST_FULL_BIT]          = fifo_full;
    status_word[ST_UNDERRUN_BIT]      = underrun;
    status_word[ST_OVERFLOW_BIT]      = overflow;
    status_word[ST_IDX_LSB +: 3]      = idx;
    case (addr_i)
      CTRL_OFS:   rdata_o = {30'd0, irq_en, enable};
      DIV_OFS:    rdata_o = 32'(div_q);
      STATUS_OFS: rdata_o = status_word;
      default:    rdata_o = '0;
    endcase
  end

endmodule

// File: tb/tb_audio_pwm_mc.sv
// Directed self-checking bench for audio_pwm_mc (default configuration).
module tb_audio_pwm_mc;
  import audio_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we_i = 1'b0;
  logic [1:0]  addr_i = 2'd0;
  logic [31:0] wdata_i = 32'd0;
  logic [31:0] rdata_o;
  logic [1:0]  pwm_o;
  logic        irq_o;

  int n_vec = 0;
  int n_err = 0;

  audio_pwm_mc dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (we_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .rdata_o (rdata_o),
    .pwm_o   (pwm_o),
    .irq_o   (irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All tasks start and end at a negedge
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we_i = 1'b1; addr_i = a; wdata_i = d;
    @(negedge clk);
    we_i = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    addr_i = a;
    #1;
    d = rdata_o;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic count_high(output int h0, output int h1);
    h0 = 0; h1 = 0;
    repeat (256) begin
      @(negedge clk);
      h0 += int'(pwm_o[0]);
      h1 += int'(pwm_o[1]);
    end
  endtask

  initial begin
    logic [31:0] d;
    int h0, h1;
    bit found;

    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    rd(STATUS_OFS, d); chk("rst_status", d, 32'h100);
    chk("rst_pwm", 32'(pwm_o), 32'd0);
    chk("rst_irq", 32'(irq_o), 32'd0);

    // Two-channel playback: 0x40 and 0xC0 duty
    wr(DATA_OFS, 32'h40);
    wr(DATA_OFS, 32'hC0);
    wr(DIV_OFS, 32'd3);
    rd(DIV_OFS, d); chk("div_rd", d, 32'd3);
    rd(DATA_OFS, d); chk("data_rd_zero", d, 32'd0);
    wr(CTRL_OFS, 32'h1);
    idle(300);
    count_high(h0, h1);
    chk("duty_ch0", 32'(h0), 32'd64);
    chk("duty_ch1", 32'(h1), 32'd192);

    // Overflow with 17 frames into a 16-deep FIFO, then W1C
    do_reset();
    for (int i = 0; i < 34; i++) wr(DATA_OFS, 32'(i));
    rd(STATUS_OFS, d); chk("ovf_status", d, 32'hA10);
    wr(STATUS_OFS, 32'h800);
    rd(STATUS_OFS, d); chk("ovf_clear", d, 32'h210);

    // Underrun on empty FIFO with DIV=0
    do_reset();
    wr(CTRL_OFS, 32'h1);
    idle(1);
    rd(STATUS_OFS, d); chk("udr_status", d, 32'h500);
    count_high(h0, h1);
    chk("udr_pwm0", 32'(h0), 32'd0);
    chk("udr_pwm1", 32'(h1), 32'd0);

    // Push lands in the same cycle as a tick on empty FIFO: still underrun
    do_reset();
    wr(DATA_OFS, 32'h10);
    wr(DIV_OFS, 32'd5);
    wr(CTRL_OFS, 32'h1);
    idle(5);
    wr(DATA_OFS, 32'h20);
    rd(STATUS_OFS, d); chk("nobypass_status", d, 32'h401);

    // Watermark irq
    do_reset();
    for (int i = 0; i < 12; i++) wr(DATA_OFS, 32'(i));
    wr(DIV_OFS, 32'd9);
    wr(CTRL_OFS, 32'h3);
    chk("irq_above_wm", 32'(irq_o), 32'd0);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      idle(1);
      rd(STATUS_OFS, d);
      if (d[7:0] == 8'd4) found = 1'b1;
    end
    chk("irq_lvl4_seen", 32'(found), 32'd1);
    chk("irq_at_lvl4", 32'(irq_o), 32'd0);
    idle(1);
    chk("irq_rise", 32'(irq_o), 32'd1);
    wr(DATA_OFS, 32'h1);
    wr(DATA_OFS, 32'h2);
    chk("irq_hold", 32'(irq_o), 32'd1);
    rd(STATUS_OFS, d); chk("irq_lvl5", {24'd0, d[7:0]}, 32'd5);
    idle(1);
    chk("irq_fall", 32'(irq_o), 32'd0);

    // Flush discards a half-staged frame
    do_reset();
    wr(DATA_OFS, 32'h11);
    rd(STATUS_OFS, d); chk("stage_idx1", d, 32'h1100);
    wr(CTRL_OFS, 32'h4);
    rd(STATUS_OFS, d); chk("flush_status", d, 32'h100);
    rd(CTRL_OFS, d); chk("flush_selfclr", d, 32'd0);
    wr(DATA_OFS, 32'h22);
    wr(DATA_OFS, 32'h33);
    rd(STATUS_OFS, d); chk("fresh_frame", d, 32'h001);
    wr(CTRL_OFS, 32'h1);
    idle(600);
    count_high(h0, h1);
    chk("fresh_ch0", 32'(h0), 32'd34);
    chk("fresh_ch1", 32'(h1), 32'd51);

    // Reset during playback
    do_reset();
    chk("midrst_pwm", 32'(pwm_o), 32'd0);
    chk("midrst_irq", 32'(irq_o), 32'd0);
    rd(STATUS_OFS, d); chk("midrst_status", d, 32'h100);
    rd(CTRL_OFS, d); chk("midrst_ctrl", d, 32'd0);
    rd(DIV_OFS, d); chk("midrst_div", d, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
